scan_link_receiver: RTL and testbench
=====================================

# scan_link_receiver

Downstream stage of the scanner's serial command/data link. It samples the scanner's gated serial clock and data lines in the local `clk` domain and deserializes LSB-first 8-bit frames. It decodes command codes into one-cycle event pulses and queues transferred data bytes in a small FIFO for the consumer. It also drives the ready level back to the scanner's `readyForTransferIn`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: data byte FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 64: `clk` cycles allowed between serial edges inside a frame before abort.
- `SYNC_STAGES`, 2: synchronizer flops on `serClkIn`/`serDataIn`; ≥2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `serClkIn`  in  1  scanner serial clock (`clkOut`); asynchronous to `clk`.
- `serDataIn`  in  1  scanner serial data (`dataOut`).
- `dataRead`  in  1  consumer pop strobe.
- `readyForTransferOut`  out  1  high when at least one FIFO entry is free.
- `cmdValid`  out  1  one-cycle pulse when a command byte completes.
- `cmdCode`  out  8  last completed command byte; held until the next one.
- `evReady`  out  1  pulse with `cmdValid` when code = 2.
- `evStartScan`  out  1  pulse with `cmdValid` when code = 3.
- `evFull`  out  1  pulse with `cmdValid` when code = 4.
- `dataAvail`  out  1  FIFO not empty.
- `dataByte`  out  8  FIFO head; valid when `dataAvail`.
- `fifoCount`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a data byte was dropped because the FIFO was full.
- `frameErr`  out  1  one-cycle pulse on timeout abort or unknown command.

## Operation
- `serClkIn` and `serDataIn` each pass through `SYNC_STAGES` flops. A bit is sampled when the synchronized clock is 1 and its previous value was 0 (an edge event). Data is taken from the synchronized data stage aligned with that clock stage.
- Bits shift in LSB first into an 8-bit shift register, with a 3-bit bit counter.
- FSM states:
  - IDLE: bitCnt = 0. An edge event captures bit 0 and moves to CMD.
  - CMD: on the 8th bit, register `cmdCode` and pulse `cmdValid`.
    - Code 7 → DATA.
    - Codes 2/3/4 → IDLE, pulsing the matching `ev*`.
    - Any other code → IDLE with `frameErr`.
  - DATA: shifts 8 bits. On the 8th bit, push the byte → IDLE. If the FIFO is full and there is no pop in the same cycle, drop the byte and set `overflow`.
  - In CMD or DATA, a timeout counter resets on every edge event. When it reaches `TIMEOUT`: discard the partial byte, pulse `frameErr`, go to IDLE, bitCnt = 0.
- FIFO behaviour:
  - Pop when `dataRead && dataAvail`; a pop while empty is ignored.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `readyForTransferOut` is registered and equals `fifoCount_next < FIFO_DEPTH`.
- `overflow` clears only on reset.

## Timing
- Reset (rst = 0 at a clock edge) values:
  - All outputs 0, including `cmdCode` and `dataByte`.
  - FSM in IDLE; counters and pointers 0; synchronizers 0.
  - Reset mid-frame discards the partial frame and FIFO contents.
- First cycle after reset release: `readyForTransferOut` = 1.
- Edge-event cycle = `SYNC_STAGES`+1 cycles after the raw `serClkIn` rise.
- `cmdValid`, `ev*` and `frameErr` assert the cycle after the 8th-bit edge event.
- A pushed byte is visible on `dataByte`/`dataAvail` the cycle after the 8th data-bit edge event.
- After a pop, `dataByte` shows the next entry the following cycle.
- The serial clock high and low phases must each last ≥ `SYNC_STAGES`+1 `clk` cycles; faster input is out of spec.
- Timeout abort occurs exactly `TIMEOUT` cycles after the last edge event.

## Structure
- Shared package `scan_link_pkg`:
  - Command codes: `CMD_READY`=2, `CMD_START`=3, `CMD_FULL`=4, `CMD_DATA`=7 (also used by the scanner).
  - FSM state enum {IDLE, CMD, DATA}.
- One sub-module: `byte_fifo` (parameterized depth, push/pop/count/full/empty). The synchronizer, FSM and shift register stay inline.

## Test plan
- Send code 0x02 → one `cmdValid`+`evReady` pulse, `cmdCode`=0x02; no FIFO change.
- Send 0x07 then 0xA5 → `cmdValid` with code 7; then `dataAvail`=1, `dataByte`=0xA5, `fifoCount`=1.
- Send 5 data frames (0x01..0x05) with no reads, depth 4:
  - `fifoCount`=4 and `readyForTransferOut`=0 after the 4th frame.
  - 0x05 dropped, `overflow`=1.
  - Reads return 0x01..0x04 in order.
- Stop the serial clock after 3 bits of a command:
  - `frameErr` pulses 64 cycles after the last edge.
  - A following clean 0x03 frame yields `evStartScan`.
- Send unknown code 0x09 → `cmdValid` and `frameErr` pulse, no `ev*`, state returns to IDLE.
- Assert `rst` low mid-data-byte with 2 bytes queued → all outputs 0 and `fifoCount`=0; the next full frame decodes correctly.

Source files
------------

// File: rtl/scan_link_pkg.sv
// ---------------------------------------------------------------------------
// scan_link_pkg
//   Definitions shared by both ends of the scanner serial command/data link.
//   Contents:
//     CMD_READY / CMD_START / CMD_FULL / CMD_DATA : command byte codes
//     rxState_e   : receiver frame state (IDLE, CMD, DATA)
//     isEventCmd  : true for command codes that map onto an event pulse
// ---------------------------------------------------------------------------
package scan_link_pkg;

  localparam logic [7:0] CMD_READY = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_FULL  = 8'h04;
  localparam logic [7:0] CMD_DATA  = 8'h07;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } rxState_e;

  // Codes that complete a transaction on their own and raise an ev* pulse.
  function automatic logic isEventCmd(input logic [7:0] code);
    return (code == CMD_READY) || (code == CMD_START) || (code == CMD_FULL);
  endfunction

endpackage

// File: rtl/scan_link_receiver_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//   Small synchronous byte FIFO holding received data bytes until the
//   consumer pops them.
//   Ports:
//     clk          : system clock, rising edge
//     rst          : synchronous active-low reset (empties the FIFO)
//     push_i       : write data_i this cycle (ignored when full unless a pop
//                    happens in the same cycle)
//     data_i       : byte to write
//     pop_i        : remove the head entry (ignored when empty)
//     data_o       : head entry, forced to 0 while empty
//     count_o      : current occupancy
//     countNext_o  : occupancy after this cycle's push/pop
//     full_o       : all DEPTH entries used
//     empty_o      : no entries
// ---------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     countNext_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          doPush, doPop;

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a push when it is being read at the same time.
  always_comb begin
    doPop   = pop_i && (count_q != '0);
    doPush  = push_i && ((count_q != CW'(DEPTH)) || doPop);
    wrPtr_d = wrPtr_q + PW'(doPush);
    rdPtr_d = rdPtr_q + PW'(doPop);
    count_d = count_q + CW'(doPush) - CW'(doPop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  always_comb begin
    empty_o     = (count_q == '0);
    full_o      = (count_q == CW'(DEPTH));
    count_o     = count_q;
    countNext_o = count_d;
    data_o      = empty_o ? 8'h00 : mem_q[rdPtr_q];
  end

endmodule

// File: rtl/scan_link_receiver.sv
// ---------------------------------------------------------------------------
// scan_link_receiver
//   Receiving end of the scanner serial link. Synchronizes the scanner's
//   gated serial clock and data into clk, deserializes LSB-first 8-bit
//   frames, turns command bytes into one-cycle event pulses and queues data
//   bytes (those following a CMD_DATA command) in a byte FIFO.
//   Ports:
//     clk                 : system clock, rising edge
//     rst                 : synchronous active-low reset
//     serClkIn            : scanner serial clock, asynchronous to clk
//     serDataIn           : scanner serial data
//     dataRead            : consumer pop strobe
//     readyForTransferOut : registered, high while a FIFO entry is free
//     cmdValid            : pulse when a command byte completes
//     cmdCode             : last completed command byte
//     evReady/evStartScan/evFull : pulses alongside cmdValid for codes 2/3/4
//     dataAvail           : FIFO not empty
//     dataByte            : FIFO head
//     fifoCount           : FIFO occupancy
//     overflow            : sticky, a data byte was dropped on a full FIFO
//     frameErr            : pulse on inter-edge timeout or unknown command
// ---------------------------------------------------------------------------
module scan_link_receiver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serClkIn,
  input  logic                          serDataIn,
  input  logic                          dataRead,
  output logic                          readyForTransferOut,
  output logic                          cmdValid,
  output logic [7:0]                    cmdCode,
  output logic                          evReady,
  output logic                          evStartScan,
  output logic                          evFull,
  output logic                          dataAvail,
  output logic [7:0]                    dataByte,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow,
  output logic                          frameErr
);

  import scan_link_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] syncClk_q, syncClk_d;
  logic [SYNC_STAGES-1:0] syncData_q, syncData_d;
  logic                   clkPrev_q, clkPrev_d;

  rxState_e               state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [TW-1:0]          timeoutCnt_q, timeoutCnt_d;
  logic [7:0]             cmdCode_q, cmdCode_d;
  logic                   cmdValid_q, cmdValid_d;
  logic                   frameErr_q, frameErr_d;
  logic                   overflow_q, overflow_d;
  logic                   ready_q, ready_d;

  logic                   edgeEvent;
  logic                   serBit;
  logic [7:0]             shiftNext;

  logic                   fifoPush;
  logic                   fifoPop;
  logic [7:0]             fifoHead;
  logic [CW-1:0]          fifoCountQ;
  logic [CW-1:0]          fifoCountNext;
  logic                   fifoFull;
  logic                   fifoEmpty;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifoPush),
    .data_i      (shiftNext),
    .pop_i       (fifoPop),
    .data_o      (fifoHead),
    .count_o     (fifoCountQ),
    .countNext_o (fifoCountNext),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // Data is taken from the same synchronizer depth as the clock so both
  // lines see identical latency; an edge event is a 0->1 step at the last
  // clock stage.
  assign serBit    = syncData_q[SYNC_STAGES-1];
  assign edgeEvent = syncClk_q[SYNC_STAGES-1] && !clkPrev_q;
  assign shiftNext = {serBit, shift_q[7:1]};
  assign fifoPop   = dataRead && !fifoEmpty;

  // State register: FSM state, synchronizers, datapath and registered
  // outputs all load together; reset wipes any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      syncClk_q    <= '0;
      syncData_q   <= '0;
      clkPrev_q    <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      timeoutCnt_q <= '0;
      cmdCode_q    <= '0;
      cmdValid_q   <= 1'b0;
      frameErr_q   <= 1'b0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      syncClk_q    <= syncClk_d;
      syncData_q   <= syncData_d;
      clkPrev_q    <= clkPrev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      cmdCode_q    <= cmdCode_d;
      cmdValid_q   <= cmdValid_d;
      frameErr_q   <= frameErr_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic: shifts bits on edge events, decodes a completed
  // command byte, pushes a completed data byte and aborts a frame whose
  // serial clock stalls for TIMEOUT cycles. An edge event in the same cycle
  // as the timeout limit wins, since the link is still alive.
  always_comb begin
    syncClk_d    = {syncClk_q[SYNC_STAGES-2:0], serClkIn};
    syncData_d   = {syncData_q[SYNC_STAGES-2:0], serDataIn};
    clkPrev_d    = syncClk_q[SYNC_STAGES-1];
    state_d      = state_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    cmdCode_d    = cmdCode_q;
    cmdValid_d   = 1'b0;
    frameErr_d   = 1'b0;
    overflow_d   = overflow_q;
    fifoPush     = 1'b0;

    case (state_q)
      IDLE: begin
        bitCnt_d     = '0;
        timeoutCnt_d = '0;
        if (edgeEvent) begin
          shift_d  = shiftNext;
          bitCnt_d = 3'd1;
          state_d  = CMD;
        end
      end

      CMD, DATA: begin
        if (edgeEvent) begin
          timeoutCnt_d = '0;
          shift_d      = shiftNext;
          bitCnt_d     = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = IDLE;
            if (state_q == CMD) begin
              cmdCode_d  = shiftNext;
              cmdValid_d = 1'b1;
              if (shiftNext == CMD_DATA) begin
                state_d = DATA;
              end else if (!isEventCmd(shiftNext)) begin
                frameErr_d = 1'b1;
              end
            end else begin
              fifoPush = 1'b1;
              if (fifoFull && !fifoPop) begin
                overflow_d = 1'b1;
              end
            end
          end
        end else if (timeoutCnt_q == TW'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          bitCnt_d     = '0;
          shift_d      = '0;
          timeoutCnt_d = '0;
          frameErr_d   = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        bitCnt_d = '0;
      end
    endcase

    ready_d = (fifoCountNext < CW'(FIFO_DEPTH));
  end

  // Output logic: event pulses are decoded from the registered command
  // strobe so they line up exactly with cmdValid.
  always_comb begin
    readyForTransferOut = ready_q;
    cmdValid            = cmdValid_q;
    cmdCode             = cmdCode_q;
    evReady             = cmdValid_q && (cmdCode_q == CMD_READY);
    evStartScan         = cmdValid_q && (cmdCode_q == CMD_START);
    evFull              = cmdValid_q && (cmdCode_q == CMD_FULL);
    dataAvail           = !fifoEmpty;
    dataByte            = fifoHead;
    fifoCount           = fifoCountQ;
    overflow            = overflow_q;
    frameErr            = frameErr_q;
  end

endmodule

// File: tb/tb_scan_link_receiver.sv
// ---------------------------------------------------------------------------
// tb_scan_link_receiver
//   Directed bench for scan_link_receiver with default parameters
//   (FIFO_DEPTH=4, TIMEOUT=64, SYNC_STAGES=2). Serial bits use 4-cycle low
//   and high phases. applyStimulus leaves the bench one cycle after the
//   edge-event register update of the 8th bit, where the one-cycle pulses
//   are visible.
// ---------------------------------------------------------------------------
module tb_scan_link_receiver;

  logic       clk;
  logic       rst;
  logic       serClkIn;
  logic       serDataIn;
  logic       dataRead;
  logic       readyForTransferOut;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       evReady;
  logic       evStartScan;
  logic       evFull;
  logic       dataAvail;
  logic [7:0] dataByte;
  logic [2:0] fifoCount;
  logic       overflow;
  logic       frameErr;

  int errors = 0;
  int checks = 0;

  scan_link_receiver #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (64),
    .SYNC_STAGES(2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .serClkIn           (serClkIn),
    .serDataIn          (serDataIn),
    .dataRead           (dataRead),
    .readyForTransferOut(readyForTransferOut),
    .cmdValid           (cmdValid),
    .cmdCode            (cmdCode),
    .evReady            (evReady),
    .evStartScan        (evStartScan),
    .evFull             (evFull),
    .dataAvail          (dataAvail),
    .dataByte           (dataByte),
    .fifoCount          (fifoCount),
    .overflow           (overflow),
    .frameErr           (frameErr)
  );

  // Free-running 100 MHz-style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full serial bit: 4-cycle low phase with data set up, 4-cycle high.
  task automatic sendBit(input logic b);
    serDataIn = b;
    serClkIn  = 1'b0;
    tick(4);
    serClkIn  = 1'b1;
    tick(4);
    serClkIn  = 1'b0;
  endtask

  // Whole LSB-first frame. Returns 3 edges after the 8th raw rise, i.e. in
  // the cycle where cmdValid/ev*/frameErr pulse or a pushed byte shows up.
  // popAtEnd raises dataRead exactly in the push cycle.
  task automatic applyStimulus(input logic [7:0] value, input logic popAtEnd);
    for (int i = 0; i < 7; i++) sendBit(value[i]);
    serDataIn = value[7];
    serClkIn  = 1'b0;
    tick(4);
    serClkIn  = 1'b1;
    tick(2);
    dataRead  = popAtEnd;
    tick(1);
    dataRead  = 1'b0;
  endtask

  task automatic popOne();
    dataRead = 1'b1;
    tick(1);
    dataRead = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    serClkIn  = 1'b0;
    serDataIn = 1'b0;
    dataRead  = 1'b0;
    $display("[TB] start");

    // Reset values
    tick(3);
    checkOutput("rst_ready", readyForTransferOut, 0);
    checkOutput("rst_cmdValid", cmdValid, 0);
    checkOutput("rst_cmdCode", cmdCode, 0);
    checkOutput("rst_dataAvail", dataAvail, 0);
    checkOutput("rst_dataByte", dataByte, 0);
    checkOutput("rst_fifoCount", fifoCount, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_frameErr", frameErr, 0);
    rst = 1'b1;
    tick(1);
    checkOutput("release_ready", readyForTransferOut, 1);

    // Command 0x02
    applyStimulus(8'h02, 1'b0);
    checkOutput("ready_cmdValid", cmdValid, 1);
    checkOutput("ready_evReady", evReady, 1);
    checkOutput("ready_evStart", evStartScan, 0);
    checkOutput("ready_evFull", evFull, 0);
    checkOutput("ready_frameErr", frameErr, 0);
    checkOutput("ready_cmdCode", cmdCode, 8'h02);
    checkOutput("ready_fifoCount", fifoCount, 0);
    tick(1);
    checkOutput("ready_cmdValidOff", cmdValid, 0);
    checkOutput("ready_evReadyOff", evReady, 0);
    checkOutput("ready_cmdCodeHeld", cmdCode, 8'h02);

    // Data transfer 0x07, 0xA5
    applyStimulus(8'h07, 1'b0);
    checkOutput("data_cmdValid", cmdValid, 1);
    checkOutput("data_cmdCode", cmdCode, 8'h07);
    checkOutput("data_frameErr", frameErr, 0);
    checkOutput("data_dataAvailPre", dataAvail, 0);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("data_dataAvail", dataAvail, 1);
    checkOutput("data_dataByte", dataByte, 8'hA5);
    checkOutput("data_fifoCount", fifoCount, 1);
    checkOutput("data_noCmdValid", cmdValid, 0);
    popOne();
    checkOutput("data_popAvail", dataAvail, 0);
    checkOutput("data_popCount", fifoCount, 0);
    popOne();
    checkOutput("data_popEmptyCount", fifoCount, 0);

    // Fill FIFO with 0x01..0x04
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(8'h07, 1'b0);
      applyStimulus(8'(i), 1'b0);
    end
    checkOutput("full_fifoCount", fifoCount, 4);
    checkOutput("full_ready", readyForTransferOut, 0);
    checkOutput("full_overflow", overflow, 0);
    checkOutput("full_head", dataByte, 8'h01);

    // Push 0x05 with a pop in the same cycle: no drop
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h05, 1'b1);
    checkOutput("pushPop_count", fifoCount, 4);
    checkOutput("pushPop_head", dataByte, 8'h02);
    checkOutput("pushPop_overflow", overflow, 0);
    checkOutput("pushPop_ready", readyForTransferOut, 0);

    // Push 0x06 with no pop: dropped
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h06, 1'b0);
    checkOutput("drop_count", fifoCount, 4);
    checkOutput("drop_overflow", overflow, 1);

    // Drain: 0x02..0x05 in order
    for (int i = 2; i <= 5; i++) begin
      checkOutput("drain_byte", dataByte, i);
      popOne();
    end
    checkOutput("drain_avail", dataAvail, 0);
    checkOutput("drain_ready", readyForTransferOut, 1);
    checkOutput("drain_overflowSticky", overflow, 1);

    // Stall after 3 bits of a command
    sendBit(1'b1);
    sendBit(1'b0);
    serDataIn = 1'b1;
    serClkIn  = 1'b0;
    tick(4);
    serClkIn  = 1'b1;
    tick(66);
    checkOutput("timeout_early", frameErr, 0);
    tick(1);
    checkOutput("timeout_pulse", frameErr, 1);
    checkOutput("timeout_noCmdValid", cmdValid, 0);
    tick(1);
    checkOutput("timeout_off", frameErr, 0);
    applyStimulus(8'h03, 1'b0);
    checkOutput("afterTimeout_evStart", evStartScan, 1);
    checkOutput("afterTimeout_cmdCode", cmdCode, 8'h03);
    checkOutput("afterTimeout_frameErr", frameErr, 0);

    // Unknown command 0x09
    applyStimulus(8'h09, 1'b0);
    checkOutput("unknown_cmdValid", cmdValid, 1);
    checkOutput("unknown_frameErr", frameErr, 1);
    checkOutput("unknown_cmdCode", cmdCode, 8'h09);
    checkOutput("unknown_evAny", {evReady, evStartScan, evFull}, 0);
    applyStimulus(8'h04, 1'b0);
    checkOutput("afterUnknown_evFull", evFull, 1);
    checkOutput("afterUnknown_frameErr", frameErr, 0);
    checkOutput("afterUnknown_fifoCount", fifoCount, 0);

    // Reset mid data byte with 2 bytes queued
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h07, 1'b0);
    applyStimulus(8'h22, 1'b0);
    checkOutput("preReset_count", fifoCount, 2);
    applyStimulus(8'h07, 1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    rst = 1'b0;
    tick(1);
    checkOutput("midRst_ready", readyForTransferOut, 0);
    checkOutput("midRst_cmdValid", cmdValid, 0);
    checkOutput("midRst_cmdCode", cmdCode, 0);
    checkOutput("midRst_dataAvail", dataAvail, 0);
    checkOutput("midRst_dataByte", dataByte, 0);
    checkOutput("midRst_fifoCount", fifoCount, 0);
    checkOutput("midRst_overflow", overflow, 0);
    checkOutput("midRst_frameErr", frameErr, 0);
    rst = 1'b1;
    tick(1);
    checkOutput("midRst_releaseReady", readyForTransferOut, 1);
    applyStimulus(8'h07, 1'b0);
    checkOutput("postRst_cmdCode", cmdCode, 8'h07);
    checkOutput("postRst_cmdValid", cmdValid, 1);
    applyStimulus(8'h3C, 1'b0);
    checkOutput("postRst_dataByte", dataByte, 8'h3C);
    checkOutput("postRst_fifoCount", fifoCount, 1);
    checkOutput("postRst_frameErr", frameErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
